// File: rtl/muldiv_iter.sv
// Iterative RV64M multiply/divide unit: radix-2 shift-add multiply, restoring divide.
// Optional MULDIV_RV64W_EN adds 32-bit word ops (op_w) with sign-extended results.
module muldiv_iter #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 7
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic            op_w,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            flush,
  output logic            busy,
  output logic            stall_req,
  output logic            done,
  output logic [XLEN-1:0] result
);

  // state | meaning
  // IDLE  | waiting for start
  // CALC  | one multiply/divide step per cycle, counter running
  // DONE  | sign fix and result select, registered with done at the next edge
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t state_q, state_d;

  logic [CNT_W-1:0]  cnt_q;
  logic [2*XLEN-1:0] acc_q;
  logic [XLEN-1:0]   opb_q;
  logic [2:0]        f3_q;
  logic              neg_q;
  logic              rem_neg_q;
  logic              word_q;
  logic              special_q;
  logic [XLEN-1:0]   special_val_q;
  logic [XLEN-1:0]   result_q;
  logic              done_q;

  // launch decode
  logic              word_sel;
  logic              signed_a, signed_b;
  logic [XLEN-1:0]   opa_ext, opb_ext, rem_dz, min_val;
  logic              sign_a, sign_b;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic              b_zero, div_ovf, special;
  logic [XLEN-1:0]   special_val;
  logic [CNT_W-1:0]  cnt_load;
  logic [2*XLEN-1:0] acc_load;

  logic unused_op_w;
  assign unused_op_w = op_w;

  always_comb begin
    signed_a = (funct3 == 3'd1) || (funct3 == 3'd2) || (funct3 == 3'd4) || (funct3 == 3'd6);
    signed_b = (funct3 == 3'd1) || (funct3 == 3'd4) || (funct3 == 3'd6);
    word_sel = 1'b0;
    opa_ext  = rs1_data;
    opb_ext  = rs2_data;
    rem_dz   = rs1_data;
    min_val  = {1'b1, {(XLEN-1){1'b0}}};
    cnt_load = CNT_W'(XLEN);
`ifdef MULDIV_RV64W_EN
    word_sel = op_w;
    if (op_w) begin
      opa_ext  = {{(XLEN-32){signed_a & rs1_data[31]}}, rs1_data[31:0]};
      opb_ext  = {{(XLEN-32){signed_b & rs2_data[31]}}, rs2_data[31:0]};
      rem_dz   = {{(XLEN-32){rs1_data[31]}}, rs1_data[31:0]};
      min_val  = {{(XLEN-31){1'b1}}, {31{1'b0}}};
      cnt_load = CNT_W'(32);
    end
`endif
    sign_a  = signed_a & opa_ext[XLEN-1];
    sign_b  = signed_b & opb_ext[XLEN-1];
    mag_a   = sign_a ? -opa_ext : opa_ext;
    mag_b   = sign_b ? -opb_ext : opb_ext;
    b_zero  = funct3[2] && (opb_ext == '0);
    div_ovf = funct3[2] && !funct3[0] && (opa_ext == min_val) && (opb_ext == '1);
    special = b_zero || div_ovf;
    if (b_zero)
      special_val = funct3[1] ? rem_dz : '1;
    else
      special_val = funct3[1] ? '0 : opa_ext;
    // multiply keeps the multiplier in the low half; divide keeps the dividend there
    if (!funct3[2])
      acc_load = {{XLEN{1'b0}}, mag_b};
    else if (word_sel)
      acc_load = {{XLEN{1'b0}}, mag_a[31:0], {(XLEN-32){1'b0}}};
    else
      acc_load = {{XLEN{1'b0}}, mag_a};
  end

  // one iteration step
  logic [XLEN:0]     mul_sum, div_trial, div_diff;
  logic [2*XLEN-1:0] acc_step;

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    div_trial = acc_q[2*XLEN-1:XLEN-1];
    div_diff  = div_trial - {1'b0, opb_q};
    if (!f3_q[2])
      acc_step = {mul_sum, acc_q[XLEN-1:1]};
    else if (!div_diff[XLEN])
      acc_step = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    else
      acc_step = {acc_q[2*XLEN-2:0], 1'b0};
  end

  // sign fix and output select
  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0]   quot_fix, rem_fix, sel;

  always_comb begin
    prod = acc_q;
`ifdef MULDIV_RV64W_EN
    // after 32 steps the word product sits 32 bits up in the accumulator
    if (word_q)
      prod = {{XLEN{1'b0}}, acc_q[XLEN+31:32]};
`endif
    prod_fix = neg_q ? -prod : prod;
    quot_fix = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem_fix  = rem_neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    case (f3_q)
      3'd0:                sel = prod_fix[XLEN-1:0];
      3'd1, 3'd2, 3'd3:    sel = word_q ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
      3'd4, 3'd5:          sel = quot_fix;
      default:             sel = rem_fix;
    endcase
    if (word_q)
      sel = {{(XLEN-32){sel[31]}}, sel[31:0]};
    if (special_q)
      sel = special_val_q;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start && !flush) state_d = special ? DONE : CALC;
      CALC: begin
        if (flush)
          state_d = IDLE;
        else if (cnt_q == CNT_W'(1))
          state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      acc_q         <= '0;
      opb_q         <= '0;
      f3_q          <= '0;
      neg_q         <= 1'b0;
      rem_neg_q     <= 1'b0;
      word_q        <= 1'b0;
      special_q     <= 1'b0;
      special_val_q <= '0;
      result_q      <= '0;
      done_q        <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start && !flush) begin
            f3_q          <= funct3;
            word_q        <= word_sel;
            neg_q         <= sign_a ^ sign_b;
            rem_neg_q     <= sign_a;
            special_q     <= special;
            special_val_q <= special_val;
            acc_q         <= acc_load;
            opb_q         <= funct3[2] ? mag_b : mag_a;
            cnt_q         <= cnt_load;
          end
        end
        CALC: begin
          if (!flush) begin
            acc_q <= acc_step;
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        DONE: begin
          if (!flush) begin
            result_q <= sel;
            done_q   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state_q != IDLE);
  assign stall_req = ((state_q == IDLE) && start) || (state_q == CALC);
  assign done      = done_q;
  assign result    = result_q;

endmodule

// File: tb/tb_muldiv_iter.sv
// Directed bench for muldiv_iter (XLEN=64): results, latency, stall, flush and reset.
module tb_muldiv_iter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic        op_w = 1'b0;
  logic [63:0] rs1_data = '0;
  logic [63:0] rs2_data = '0;
  logic        flush = 1'b0;
  logic        busy, stall_req, done;
  logic [63:0] result;

  int n_checks = 0;
  int n_pass   = 0;
  int done_cnt = 0;
  int d0;
  logic [63:0] prev;

  muldiv_iter #(.XLEN(64), .CNT_W(7)) dut (
    .clk(clk), .reset(reset), .start(start), .funct3(funct3), .op_w(op_w),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .flush(flush),
    .busy(busy), .stall_req(stall_req), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (done) done_cnt <= done_cnt + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // called #1 after a rising edge with the unit idle
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] exp, input int exp_lat,
                        input int exp_stall);
    int cyc;
    int st;
    funct3 = f3; rs1_data = a; rs2_data = b; start = 1'b1;
    #1;
    chk({tag, " launch stall"}, 64'(stall_req), 64'd1);
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0; st = 0;
    while (!done && cyc < 200) begin
      if (stall_req) st++;
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, " latency"}, 64'(cyc), 64'(exp_lat));
    chk({tag, " result"}, result, exp);
    chk({tag, " stall cycles"}, 64'(st), 64'(exp_stall));
  endtask

  initial begin
    #1 reset = 1'b1;
    #1;
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset stall", 64'(stall_req), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset result", result, 64'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    run_op("DIV -7/2",  3'd4, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65, 64);
    run_op("REM -7%2",  3'd6, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65, 64);
    run_op("DIVU by 0", 3'd5, 64'h1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0);
    run_op("REMU by 0", 3'd7, 64'h1234, 64'd0, 64'h1234, 1, 0);
    run_op("DIV ovf",   3'd4, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
           64'h8000_0000_0000_0000, 1, 0);
    run_op("REM ovf",   3'd6, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1, 0);
    run_op("MUL min*2",   3'd0, 64'h8000_0000_0000_0000, 64'd2, 64'd0, 65, 64);
    run_op("MULH min*2",  3'd1, 64'h8000_0000_0000_0000, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65, 64);
    run_op("MULHU min*2", 3'd3, 64'h8000_0000_0000_0000, 64'd2, 64'd1, 65, 64);
    run_op("MULHSU -1*-1", 3'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
           64'hFFFF_FFFF_FFFF_FFFF, 65, 64);

    // start together with flush while idle is ignored
    funct3 = 3'd0; rs1_data = 64'd4; rs2_data = 64'd4;
    start = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    chk("start+flush idle busy", 64'(busy), 64'd0);

    // flush an in-flight DIVU at cycle 10
    prev = result;
    d0 = done_cnt;
    funct3 = 3'd5; rs1_data = 64'd100; rs2_data = 64'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush busy", 64'(busy), 64'd0);
    chk("flush result kept", result, prev);
    run_op("MUL 3*5", 3'd0, 64'd3, 64'd5, 64'd15, 65, 64);
    chk("flush no done", 64'(done_cnt - d0), 64'd0);

    // reset at cycle 20 of a MUL, with start re-pulsed during CALC
    @(posedge clk); #1;
    d0 = done_cnt;
    funct3 = 3'd0; rs1_data = 64'd7; rs2_data = 64'd9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1 start = 1'b1; funct3 = 3'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    chk("repulse busy", 64'(busy), 64'd1);
    chk("repulse no done", 64'(done_cnt - d0), 64'd0);
    reset = 1'b1;
    #1;
    chk("midop reset busy", 64'(busy), 64'd0);
    chk("midop reset stall", 64'(stall_req), 64'd0);
    chk("midop reset done", 64'(done), 64'd0);
    chk("midop reset result", result, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    run_op("MULHU max*max", 3'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
           64'hFFFF_FFFF_FFFF_FFFE, 65, 64);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
